opc2_boot_ctrl: RTL and testbench

OPC2_BOOT_CTRL -- requirements
Module: opc2_boot_ctrl

---
 rtl/opc2_pkg.sv | 42 ++++
 rtl/opc2_bus_mux.sv | 29 ++
 rtl/opc2_boot_ctrl.sv | 174 +++++++++++++++++
 tb/tb_opc2_boot_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opc2_pkg.sv
// Shared definitions for the opc2 boot loader: bus widths, state encoding and
// the order in which header bytes arrive on the load stream.
package opc2_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [3:0] {
        StIdle,
        StAddrH,
        StAddrL,
        StLenH,
        StLenL,
        StData,
        StCsum,
        StRelease,
        StRun,
        StError
    } opc2_state_e;

    // Header layout on the stream: address high, address low, length high, length low.
    localparam int unsigned HDR_BYTES = 4;

    function automatic opc2_state_e hdr_next(input opc2_state_e st);
        unique case (st)
            StAddrH: return StAddrL;
            StAddrL: return StLenH;
            StLenH:  return StLenL;
            default: return StAddrH;
        endcase
    endfunction

    function automatic logic st_takes_byte(input opc2_state_e st);
        return st inside {StAddrH, StAddrL, StLenH, StLenL, StData, StCsum};
    endfunction

    function automatic logic st_busy(input opc2_state_e st);
        return st inside {StAddrH, StAddrL, StLenH, StLenL, StData, StCsum, StRelease};
    endfunction

endpackage

// File: rtl/opc2_bus_mux.sv
// RAM port arbitration: the running CPU owns the bus, otherwise the loader does.
module opc2_bus_mux
    import opc2_pkg::*;
(
    input  logic              cpu_sel,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] ld_address,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    always_comb begin
        if (cpu_sel) begin
            mem_address = cpu_address;
            mem_wdata   = cpu_wdata;
            mem_we      = ~cpu_rnw;
        end else begin
            mem_address = ld_address;
            mem_wdata   = ld_wdata;
            mem_we      = ld_we;
        end
    end

endmodule

// File: rtl/opc2_boot_ctrl.sv
// Boot controller: optionally streams a program image into RAM, verifies its
// checksum, then releases the CPU from reset and hands it the memory bus.
module opc2_boot_ctrl
    import opc2_pkg::*;
#(
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              boot_en,
    input  logic              boot_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rnw,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset_b,
    output logic              busy,
    output logic              error
);

    opc2_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_reset_b_q, cpu_reset_b_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              rst_sync_q, rst_sync_d;

    logic              accept;
    logic [DATA_W-1:0] csum_chk;

    assign accept   = s_valid && s_ready_q && !boot_start;
    assign csum_chk = sum_q + s_data;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rst_sync_d = 1'b1;

        // The first edge after reset release only arms the controller.
        if (!rst_sync_q) begin
            state_d = StIdle;
        end else if (boot_start) begin
            state_d = StAddrH;
            sum_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (boot_en) begin
                        state_d = StAddrH;
                        sum_d   = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
                StAddrH: if (accept) begin
                    addr_d  = {s_data[2:0], addr_q[7:0]};
                    state_d = hdr_next(state_q);
                end
                StAddrL: if (accept) begin
                    addr_d  = {addr_q[10:8], s_data};
                    state_d = hdr_next(state_q);
                end
                StLenH: if (accept) begin
                    len_d   = {s_data[2:0], len_q[7:0]};
                    state_d = hdr_next(state_q);
                end
                StLenL: if (accept) begin
                    len_d   = {len_q[10:8], s_data};
                    state_d = ({len_q[10:8], s_data} == '0) ? StCsum : StData;
                end
                StData: if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = s_data;
                    addr_d    = addr_q + 11'd1;
                    len_d     = len_q - 11'd1;
                    sum_d     = sum_q + s_data;
                    if (len_q == 11'd1) begin
                        state_d = StCsum;
                    end
                end
                StCsum: if (accept) begin
                    cnt_d   = '0;
                    state_d = (csum_chk == '0) ? StRelease : StError;
                end
                StRelease: begin
                    if (cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun:   state_d = StRun;
                StError: state_d = StError;
                default: state_d = StIdle;
            endcase
        end

        cpu_reset_b_d = (state_d == StRun);
        s_ready_d     = st_takes_byte(state_d);
        busy_d        = st_busy(state_d);
        error_d       = (state_d == StError);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rst_sync_q    <= 1'b0;
            state_q       <= StIdle;
            addr_q        <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            cpu_reset_b_q <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            rst_sync_q    <= rst_sync_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            cpu_reset_b_q <= cpu_reset_b_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign cpu_reset_b = cpu_reset_b_q;
    assign busy        = busy_q;
    assign error       = error_q;

    opc2_bus_mux u_bus_mux (
        .cpu_sel     (cpu_reset_b_q),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rnw     (cpu_rnw),
        .ld_address  (wr_addr_q),
        .ld_wdata    (wr_data_q),
        .ld_we       (wr_en_q),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we)
    );

endmodule

// File: tb/tb_opc2_boot_ctrl.sv
// Bench for opc2_boot_ctrl: a packet-level model predicts every output each
// cycle; directed packets also pin exact writes and release timing.
module tb_opc2_boot_ctrl;

    localparam int RelCycles = 4;
    localparam int PhHold = 0, PhIdle = 1, PhLoad = 2, PhRel = 3, PhRun = 4, PhErr = 5;

    logic        clk = 1'b0;
    logic        reset_b, boot_en, boot_start, s_valid, cpu_rnw;
    logic [7:0]  s_data, cpu_wdata;
    logic [10:0] cpu_address;
    logic        s_ready, mem_we, cpu_reset_b, busy, error;
    logic [10:0] mem_address;
    logic [7:0]  mem_wdata;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int m_phase, m_pos, m_base, m_len, m_sum, m_rel_left, m_pend_a, m_pend_d;
    bit m_pend, m_acc;
    int csum_cyc, rise_cyc, rel_cyc;
    bit prev_crb = 1'b0;
    int wr_a_q[$];
    int wr_d_q[$];

    always #5 clk = ~clk;

    opc2_boot_ctrl #(.RELEASE_CYCLES(RelCycles)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .boot_en     (boot_en),
        .boot_start  (boot_start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rnw     (cpu_rnw),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .cpu_reset_b (cpu_reset_b),
        .busy        (busy),
        .error       (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = PhHold;
        m_pend  = 1'b0;
        m_acc   = 1'b0;
        m_pos   = 0;
        m_base  = 0;
        m_len   = 0;
        m_sum   = 0;
    endtask

    // Packet view: byte index into the stream decides what the byte means.
    task automatic take_byte(input int b);
        m_acc = 1'b1;
        if (m_pos == 0) m_base = (b % 8) * 256 + m_base % 256;
        else if (m_pos == 1) m_base = (m_base / 256) * 256 + b;
        else if (m_pos == 2) m_len = (b % 8) * 256 + m_len % 256;
        else if (m_pos == 3) m_len = (m_len / 256) * 256 + b;
        else if (m_pos - 4 < m_len) begin
            m_pend   = 1'b1;
            m_pend_a = (m_base + m_pos - 4) % 2048;
            m_pend_d = b;
            m_sum    = (m_sum + b) % 256;
        end else begin
            csum_cyc = cyc - 1;
            if ((m_sum + b) % 256 == 0) begin
                m_phase    = PhRel;
                m_rel_left = RelCycles;
            end else begin
                m_phase = PhErr;
            end
        end
        m_pos++;
    endtask

    task automatic model_edge();
        m_acc = 1'b0;
        if (!reset_b) return;
        m_pend = 1'b0;
        if (m_phase == PhHold) begin
            m_phase = PhIdle;
        end else if (boot_start) begin
            m_phase = PhLoad;
            m_pos   = 0;
            m_sum   = 0;
        end else begin
            case (m_phase)
                PhIdle: begin
                    if (boot_en) begin
                        m_phase = PhLoad;
                        m_pos   = 0;
                        m_sum   = 0;
                    end else begin
                        m_phase = PhRun;
                    end
                end
                PhLoad: if (s_valid) take_byte(int'(s_data));
                PhRel: begin
                    m_rel_left--;
                    if (m_rel_left == 0) m_phase = PhRun;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        cpu_address = 11'($urandom);
        cpu_wdata   = 8'($urandom);
        cpu_rnw     = 1'($urandom);
    endtask

    always @(negedge clk) begin
        check("s_ready", 32'(s_ready), 32'(m_phase == PhLoad));
        check("busy", 32'(busy), 32'(m_phase == PhLoad || m_phase == PhRel));
        check("error", 32'(error), 32'(m_phase == PhErr));
        check("cpu_reset_b", 32'(cpu_reset_b), 32'(m_phase == PhRun));
        if (m_phase == PhRun) begin
            check("cpu_mem_we", 32'(mem_we), 32'(!cpu_rnw));
            check("cpu_mem_address", 32'(mem_address), 32'(cpu_address));
            check("cpu_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        end else begin
            check("ld_mem_we", 32'(mem_we), 32'(m_pend));
            if (m_pend) begin
                check("ld_mem_address", 32'(mem_address), 32'(m_pend_a));
                check("ld_mem_wdata", 32'(mem_wdata), 32'(m_pend_d));
            end
        end
        if (mem_we === 1'b1 && cpu_reset_b === 1'b0) begin
            wr_a_q.push_back(int'(mem_address));
            wr_d_q.push_back(int'(mem_wdata));
        end
        if (cpu_reset_b === 1'b1 && !prev_crb) rise_cyc = cyc;
        prev_crb = (cpu_reset_b === 1'b1);
    end

    task automatic do_reset(input logic ben);
        reset_b    = 1'b0;
        s_valid    = 1'b0;
        boot_start = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_cpu_reset_b", 32'(cpu_reset_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        boot_en  = ben;
        reset_b  = 1'b1;
        rel_cyc  = cyc;
        rise_cyc = -1;
    endtask

    task automatic pulse_start();
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
        rise_cyc   = -1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            step();
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 64; t++) begin
            step();
            if (m_acc) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: byte %02h still not accepted after 64 cycles, required acceptance", b);
    endtask

    task automatic send_pkt(input int pk[$], input int max_gap);
        foreach (pk[i]) send(8'(pk[i]), int'($urandom_range(max_gap, 0)));
    endtask

    task automatic expect_writes(input string name, input int ea[$], input int ed[$]);
        check({name, "_count"}, 32'(wr_a_q.size()), 32'(ea.size()));
        foreach (ea[i]) begin
            if (i < wr_a_q.size()) begin
                check({name, "_addr"}, 32'(wr_a_q[i]), 32'(ea[i]));
                check({name, "_data"}, 32'(wr_d_q[i]), 32'(ed[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0; boot_en = 1'b0; boot_start = 1'b0; s_valid = 1'b0; s_data = '0;
        cpu_address = '0; cpu_wdata = '0; cpu_rnw = 1'b1;
        csum_cyc = -1; rise_cyc = -1; rel_cyc = 0;
        model_reset();

        // Run straight away: CPU released two edges after reset release.
        do_reset(1'b0);
        repeat (6) step();
        check("direct_run_delay", 32'(rise_cyc - rel_cyc), 32'd2);
        check("direct_run_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // Three-byte image at 0x100; sum AA+BB+CC = 0x31, so checksum 0xCF.
        do_reset(1'b1);
        wr_a_q.delete(); wr_d_q.delete();
        send_pkt('{'h01, 'h00, 'h00, 'h03, 'hAA, 'hBB, 'hCC, 'hCF}, 0);
        repeat (8) step();
        expect_writes("pkt_a", '{'h100, 'h101, 'h102}, '{'hAA, 'hBB, 'hCC});
        check("pkt_a_release_delay", 32'(rise_cyc - csum_cyc), 32'(RelCycles + 1));
        check("pkt_a_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // Same image with checksum 0x89: 0x31 + 0x89 != 0 mod 256.
        pulse_start();
        send_pkt('{'h01, 'h00, 'h00, 'h03, 'hAA, 'hBB, 'hCC, 'h89}, 1);
        repeat (8) step();
        check("pkt_a89_error", 32'(error), 32'd1);
        check("pkt_a89_cpu_reset_b", 32'(cpu_reset_b), 32'd0);

        // Address wrap 0x7FF -> 0x000.
        pulse_start();
        wr_a_q.delete(); wr_d_q.delete();
        send_pkt('{'h07, 'hFF, 'h00, 'h02, 'h11, 'h22, 'hCD}, 2);
        repeat (8) step();
        expect_writes("pkt_wrap", '{'h7FF, 'h000}, '{'h11, 'h22});
        check("pkt_wrap_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // Bad checksum, then restart out of ERROR.
        pulse_start();
        wr_a_q.delete(); wr_d_q.delete();
        send_pkt('{'h00, 'h10, 'h00, 'h01, 'h55, 'h00}, 0);
        repeat (8) step();
        expect_writes("pkt_bad", '{'h010}, '{'h55});
        check("pkt_bad_error", 32'(error), 32'd1);
        check("pkt_bad_cpu_reset_b", 32'(cpu_reset_b), 32'd0);
        pulse_start();
        check("restart_error", 32'(error), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_s_ready", 32'(s_ready), 32'd1);
        send_pkt('{'h00, 'h20, 'h00, 'h01, 'h77, 'h89}, 0);
        repeat (8) step();
        check("restart_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // Zero-length image: no writes at all.
        pulse_start();
        wr_a_q.delete(); wr_d_q.delete();
        send_pkt('{'h00, 'h00, 'h00, 'h00, 'h00}, 0);
        repeat (8) step();
        expect_writes("pkt_empty", '{}, '{});
        check("pkt_empty_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // boot_start collides with an offered DATA byte: byte dropped, new header wins.
        do_reset(1'b1);
        wr_a_q.delete(); wr_d_q.delete();
        send_pkt('{'h02, 'h00, 'h00, 'h04, 'h11, 'h22}, 0);
        s_valid = 1'b1; s_data = 8'h99; boot_start = 1'b1;
        step();
        boot_start = 1'b0; s_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_s_ready", 32'(s_ready), 32'd1);
        send_pkt('{'h03, 'h10, 'h00, 'h01, 'h5A, 'hA6}, 0);
        repeat (8) step();
        expect_writes("pkt_abort", '{'h200, 'h201, 'h310}, '{'h11, 'h22, 'h5A});
        check("pkt_abort_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

        // Random packets, gaps, bad checksums and mid-packet restarts.
        for (int p = 0; p < 40; p++) begin
            int addr, len, sum, csum, abort_at;
            int pk[$];
            if ($urandom_range(7, 0) == 0) begin
                do_reset(1'($urandom));
                repeat (2) step();
            end
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            pulse_start();
            s_valid = 1'b0;
            addr = int'($urandom_range(2047, 0));
            if ($urandom_range(3, 0) == 0) addr = 2047 - int'($urandom_range(3, 0));
            len = int'($urandom_range(12, 0));
            pk.delete();
            pk.push_back(addr / 256 + 8 * int'($urandom_range(31, 0)));
            pk.push_back(addr % 256);
            pk.push_back(8 * int'($urandom_range(31, 0)));
            pk.push_back(len);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                pk.push_back(int'($urandom_range(255, 0)));
                sum += pk[pk.size() - 1];
            end
            csum = (256 - sum % 256) % 256;
            if ($urandom_range(4, 0) == 0) csum = (csum + 1 + int'($urandom_range(254, 0))) % 256;
            pk.push_back(csum);
            abort_at = ($urandom_range(5, 0) == 0) ? int'($urandom_range(pk.size() - 1, 0)) : -1;
            for (int i = 0; i < pk.size(); i++) begin
                if (i == abort_at) begin
                    s_valid = 1'b1; s_data = 8'(pk[i]); boot_start = 1'b1;
                    step();
                    boot_start = 1'b0; s_valid = 1'b0;
                    break;
                end
                send(8'(pk[i]), int'($urandom_range(2, 0)));
            end
            repeat (RelCycles + 3) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
